// File: rtl/z80fi_pkg.sv
// Shared types and sizing for the Z80 formal-interface retire monitor.
// Pure declarations: no latency, no flow control.
// Optional memory-write tracing is enabled by Z80FI_MEM_TRACE_EN in the top.
package z80fi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } z80fi_state_e;

  localparam int Z80FI_MAX_INSN_LEN = 4;
  localparam int Z80FI_REG_NUM_W    = 4;
  localparam int Z80FI_LEN_W        = 3;
  localparam int Z80FI_INSN_W       = 8 * Z80FI_MAX_INSN_LEN;

  localparam logic [Z80FI_LEN_W-1:0] Z80FI_LEN_MAX = Z80FI_LEN_W'(Z80FI_MAX_INSN_LEN);

endpackage

// File: rtl/z80fi_byte_collector.sv
// Packs fetched opcode bytes little-endian and counts them, saturating at the max length.
// Next-value outputs are combinational (include this cycle's fetch); state updates on the next edge.
// No backpressure: bytes beyond the limit are dropped and flagged as overflow.
module z80fi_byte_collector
  import z80fi_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_clear,
  input  logic                    i_accept,
  input  logic                    i_fetch_vld,
  input  logic [7:0]              i_fetch_dat,
  output logic [Z80FI_INSN_W-1:0] o_insn_nxt,
  output logic [Z80FI_LEN_W-1:0]  o_len_nxt,
  output logic                    o_ovf_nxt
);

  logic [Z80FI_INSN_W-1:0] r_insn;
  logic [Z80FI_LEN_W-1:0]  r_len;
  logic                    r_ovf;

  always_comb begin
    o_insn_nxt = r_insn;
    o_len_nxt  = r_len;
    o_ovf_nxt  = r_ovf;
    if (i_accept && i_fetch_vld) begin
      if (r_len < Z80FI_LEN_MAX) begin
        for (int k = 0; k < Z80FI_MAX_INSN_LEN; k++) begin
          if (r_len == Z80FI_LEN_W'(k)) begin
            o_insn_nxt[8*k +: 8] = i_fetch_dat;
          end
        end
        o_len_nxt = r_len + Z80FI_LEN_W'(1);
      end else begin
        o_ovf_nxt = 1'b1;
      end
    end
  end

  // Clear wins over accept so a packet opened on a retire edge starts empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_insn <= '0;
      r_len  <= '0;
      r_ovf  <= 1'b0;
    end else if (i_clear) begin
      r_insn <= '0;
      r_len  <= '0;
      r_ovf  <= 1'b0;
    end else if (i_accept) begin
      r_insn <= o_insn_nxt;
      r_len  <= o_len_nxt;
      r_ovf  <= o_ovf_nxt;
    end
  end

endmodule

// File: rtl/z80fi_retire_monitor.sv
// Builds one retirement packet per Z80 instruction; Z80FI_MEM_TRACE_EN adds memory-write tracing.
// Latency: z80fi_valid pulses one cycle after insn_done, outputs hold until the next retire.
// No backpressure: the monitor observes the core and never stalls it.
module z80fi_retire_monitor
  import z80fi_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       insn_start,
  input  logic [15:0]                insn_pc,
  input  logic                       fetch_valid,
  input  logic [7:0]                 fetch_data,
  input  logic                       reg_we,
  input  logic [Z80FI_REG_NUM_W-1:0] reg_num,
  input  logic [15:0]                reg_data,
  input  logic                       insn_done,
  input  logic [15:0]                next_pc,
`ifdef Z80FI_MEM_TRACE_EN
  input  logic                       mem_we,
  input  logic [15:0]                mem_addr,
  input  logic [7:0]                 mem_data,
  output logic                       z80fi_mem_wr,
  output logic [15:0]                z80fi_mem_waddr,
  output logic [7:0]                 z80fi_mem_wdata,
`endif
  output logic                       z80fi_valid,
  output logic [Z80FI_INSN_W-1:0]    z80fi_insn,
  output logic [Z80FI_LEN_W-1:0]     z80fi_insn_len,
  output logic [15:0]                z80fi_pc_rdata,
  output logic [15:0]                z80fi_pc_wdata,
  output logic                       z80fi_reg_wr,
  output logic [Z80FI_REG_NUM_W-1:0] z80fi_reg_wnum,
  output logic [15:0]                z80fi_reg_wdata,
  output logic                       z80fi_err
);

  z80fi_state_e r_state, w_state_nxt;
  logic         r_open;
  logic         w_collect, w_clear, w_retire;

  logic [15:0]                r_pc;
  logic                       r_reg_wr, w_reg_wr_nxt;
  logic [Z80FI_REG_NUM_W-1:0] r_reg_wnum, w_reg_wnum_nxt;
  logic [15:0]                r_reg_wdata, w_reg_wdata_nxt;
  logic                       r_reg_err, w_reg_err_nxt;
  logic                       w_mem_err_nxt;
  logic                       w_err_nxt;

  logic [Z80FI_INSN_W-1:0] w_insn_nxt;
  logic [Z80FI_LEN_W-1:0]  w_len_nxt;
  logic                    w_ovf_nxt;

  logic [Z80FI_INSN_W-1:0]    r_out_insn;
  logic [Z80FI_LEN_W-1:0]     r_out_len;
  logic [15:0]                r_out_pc_rdata;
  logic [15:0]                r_out_pc_wdata;
  logic                       r_out_reg_wr;
  logic [Z80FI_REG_NUM_W-1:0] r_out_reg_wnum;
  logic [15:0]                r_out_reg_wdata;
  logic                       r_out_err;

  // EMIT still collects when the retiring cycle also opened the next instruction.
  assign w_collect = (r_state == ST_COLLECT) || ((r_state == ST_EMIT) && r_open);

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_clear     = 1'b0;
    w_retire    = 1'b0;
    if (w_collect) begin
      if (insn_done) begin
        w_retire    = 1'b1;
        w_clear     = insn_start;
        w_state_nxt = ST_EMIT;
      end else begin
        w_clear     = insn_start;
        w_state_nxt = ST_COLLECT;
      end
    end else if (insn_start) begin
      w_clear     = 1'b1;
      w_state_nxt = ST_COLLECT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_open  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_open  <= w_retire && insn_start;
    end
  end

  z80fi_byte_collector u_bytes (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (w_clear),
    .i_accept    (w_collect),
    .i_fetch_vld (fetch_valid),
    .i_fetch_dat (fetch_data),
    .o_insn_nxt  (w_insn_nxt),
    .o_len_nxt   (w_len_nxt),
    .o_ovf_nxt   (w_ovf_nxt)
  );

  always_comb begin
    w_reg_wr_nxt    = r_reg_wr;
    w_reg_wnum_nxt  = r_reg_wnum;
    w_reg_wdata_nxt = r_reg_wdata;
    w_reg_err_nxt   = r_reg_err;
    if (reg_we) begin
      w_reg_wr_nxt    = 1'b1;
      w_reg_wnum_nxt  = reg_num;
      w_reg_wdata_nxt = reg_data;
      w_reg_err_nxt   = r_reg_err || r_reg_wr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc        <= '0;
      r_reg_wr    <= 1'b0;
      r_reg_wnum  <= '0;
      r_reg_wdata <= '0;
      r_reg_err   <= 1'b0;
    end else if (w_clear) begin
      r_pc        <= insn_pc;
      r_reg_wr    <= 1'b0;
      r_reg_wnum  <= '0;
      r_reg_wdata <= '0;
      r_reg_err   <= 1'b0;
    end else if (w_collect) begin
      r_reg_wr    <= w_reg_wr_nxt;
      r_reg_wnum  <= w_reg_wnum_nxt;
      r_reg_wdata <= w_reg_wdata_nxt;
      r_reg_err   <= w_reg_err_nxt;
    end
  end

`ifdef Z80FI_MEM_TRACE_EN
  logic        r_mem_wr, w_mem_wr_nxt;
  logic [15:0] r_mem_waddr, w_mem_waddr_nxt;
  logic [7:0]  r_mem_wdata, w_mem_wdata_nxt;
  logic        r_mem_err;
  logic        r_out_mem_wr;
  logic [15:0] r_out_mem_waddr;
  logic [7:0]  r_out_mem_wdata;

  always_comb begin
    w_mem_wr_nxt    = r_mem_wr;
    w_mem_waddr_nxt = r_mem_waddr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_err_nxt   = r_mem_err;
    if (mem_we) begin
      w_mem_wr_nxt    = 1'b1;
      w_mem_waddr_nxt = mem_addr;
      w_mem_wdata_nxt = mem_data;
      w_mem_err_nxt   = r_mem_err || r_mem_wr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_wr    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_mem_err   <= 1'b0;
    end else if (w_clear) begin
      r_mem_wr    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_mem_err   <= 1'b0;
    end else if (w_collect) begin
      r_mem_wr    <= w_mem_wr_nxt;
      r_mem_waddr <= w_mem_waddr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_err   <= w_mem_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_mem_wr    <= 1'b0;
      r_out_mem_waddr <= '0;
      r_out_mem_wdata <= '0;
    end else if (w_retire) begin
      r_out_mem_wr    <= w_mem_wr_nxt;
      r_out_mem_waddr <= w_mem_waddr_nxt;
      r_out_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign z80fi_mem_wr    = r_out_mem_wr;
  assign z80fi_mem_waddr = r_out_mem_waddr;
  assign z80fi_mem_wdata = r_out_mem_wdata;
`else
  assign w_mem_err_nxt = 1'b0;
`endif

  assign w_err_nxt = w_ovf_nxt || w_reg_err_nxt || w_mem_err_nxt;

  // Packet outputs change only on a retire edge, so they hold outside EMIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_insn      <= '0;
      r_out_len       <= '0;
      r_out_pc_rdata  <= '0;
      r_out_pc_wdata  <= '0;
      r_out_reg_wr    <= 1'b0;
      r_out_reg_wnum  <= '0;
      r_out_reg_wdata <= '0;
      r_out_err       <= 1'b0;
    end else if (w_retire) begin
      r_out_insn      <= w_insn_nxt;
      r_out_len       <= w_len_nxt;
      r_out_pc_rdata  <= r_pc;
      r_out_pc_wdata  <= next_pc;
      r_out_reg_wr    <= w_reg_wr_nxt;
      r_out_reg_wnum  <= w_reg_wnum_nxt;
      r_out_reg_wdata <= w_reg_wdata_nxt;
      r_out_err       <= w_err_nxt;
    end
  end

  assign z80fi_valid     = (r_state == ST_EMIT);
  assign z80fi_insn      = r_out_insn;
  assign z80fi_insn_len  = r_out_len;
  assign z80fi_pc_rdata  = r_out_pc_rdata;
  assign z80fi_pc_wdata  = r_out_pc_wdata;
  assign z80fi_reg_wr    = r_out_reg_wr;
  assign z80fi_reg_wnum  = r_out_reg_wnum;
  assign z80fi_reg_wdata = r_out_reg_wdata;
  assign z80fi_err       = r_out_err;

endmodule
